// File: rtl/activ4_pkg.sv
// Shared definitions for the Activity 4 machine driver: state encoding,
// machine transition function and the precomputed shortest-route table.
package activ4_pkg;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} statetype;

    // ROUTE_X0/ROUTE_X1 carry the next x bit in bit 0.
    typedef enum logic [1:0] {
        ROUTE_X0 = 2'd0,
        ROUTE_X1 = 2'd1,
        ARRIVED  = 2'd2,
        UNREACH  = 2'd3
    } route_t;

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} drv_state_t;

    function automatic statetype next_state(input statetype state, input logic x);
        next_state = S0;
        case (state)
            S0: if (x) next_state = S1; else next_state = S5;
            S1: if (x) next_state = S2; else next_state = S3;
            S2: if (x) next_state = S4; else next_state = S5;
            S3: if (x) next_state = S2; else next_state = S3;
            S4: if (x) next_state = S2; else next_state = S3;
            S5: if (x) next_state = S1; else next_state = S5;
            S6: if (x) next_state = S7; else next_state = S6;
            S7: if (x) next_state = S0; else next_state = S6;
            default: next_state = S0;
        endcase
    endfunction

    // Indexed [current][target]. Paths through S0 are never used, which keeps
    // every reachable target within three steps; ties go to x=0.
    localparam route_t ROUTE_TABLE [8][8] = '{
        '{ARRIVED, ROUTE_X1, ROUTE_X1, ROUTE_X1, ROUTE_X1, ROUTE_X0, UNREACH,  UNREACH},
        '{UNREACH, ARRIVED,  ROUTE_X1, ROUTE_X0, ROUTE_X1, ROUTE_X1, UNREACH,  UNREACH},
        '{UNREACH, ROUTE_X0, ARRIVED,  ROUTE_X1, ROUTE_X1, ROUTE_X0, UNREACH,  UNREACH},
        '{UNREACH, ROUTE_X1, ROUTE_X1, ARRIVED,  ROUTE_X1, ROUTE_X1, UNREACH,  UNREACH},
        '{UNREACH, ROUTE_X1, ROUTE_X1, ROUTE_X0, ARRIVED,  ROUTE_X1, UNREACH,  UNREACH},
        '{UNREACH, ROUTE_X1, ROUTE_X1, ROUTE_X1, ROUTE_X1, ARRIVED,  UNREACH,  UNREACH},
        '{UNREACH, UNREACH,  UNREACH,  UNREACH,  UNREACH,  UNREACH,  ARRIVED,  ROUTE_X1},
        '{UNREACH, UNREACH,  UNREACH,  UNREACH,  UNREACH,  UNREACH,  ROUTE_X0, ARRIVED}
    };

endpackage

// File: rtl/activ4_route.sv
// Combinational route lookup: first x bit of a shortest path from cur to tgt,
// or ARRIVED / UNREACH.
module activ4_route
    import activ4_pkg::*;
(
    input  statetype cur,
    input  statetype tgt,
    output route_t   route
);

    assign route = ROUTE_TABLE[cur][tgt];

endmodule

// File: rtl/activ4_driver.sv
// Steers the Activity 4 machine to a requested state via x_out while tracking it
// with a shadow model. Optional y_in cross-check: define ACTIV4_SYNC_CHECK_EN.
module activ4_driver
    import activ4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_target,
    output logic       rsp_valid,
    output logic       rsp_ok,
    output logic [1:0] rsp_steps,
    output logic       x_out,
    input  logic       y_in,
    output logic [2:0] shadow_state,
    output logic       sync_err
);

    // Handshake: a request transfers on a cycle with req_valid && req_ready
    // (ready only in IDLE); the requester holds it until then. rsp_valid is a
    // single-cycle pulse with no back-pressure; rsp_ok/rsp_steps hold afterwards.

    drv_state_t state_q, state_d;
    statetype   shadow_q, shadow_d;
    statetype   tgt_q, tgt_d;
    statetype   eff_tgt;
    logic [1:0] cnt_q, cnt_d, eff_cnt;
    logic [1:0] steps_q, steps_d;
    logic       ok_q, ok_d;
    logic       evaluate;
    route_t     route;

    // In the accept cycle the route is taken straight from the request.
    assign eff_tgt = (state_q == IDLE) ? statetype'(req_target) : tgt_q;
    assign eff_cnt = (state_q == IDLE) ? 2'd0 : cnt_q;

    activ4_route u_route (
        .cur   (shadow_q),
        .tgt   (eff_tgt),
        .route (route)
    );

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        ok_d      = ok_q;
        steps_d   = steps_q;
        x_out     = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        evaluate  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    evaluate = 1'b1;
                    tgt_d    = statetype'(req_target);
                end
            end
            DRIVE: evaluate = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (evaluate) begin
            case (route)
                ROUTE_X0, ROUTE_X1: begin
                    x_out   = (route == ROUTE_X1);
                    cnt_d   = eff_cnt + 2'd1;
                    state_d = DRIVE;
                end
                ARRIVED: begin
                    ok_d    = 1'b1;
                    steps_d = eff_cnt;
                    state_d = RESP;
                end
                default: begin
                    ok_d    = 1'b0;
                    steps_d = 2'd0;
                    state_d = RESP;
                end
            endcase
        end
    end

    always_comb begin
        shadow_d = next_state(shadow_q, x_out);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= S0;
            tgt_q    <= S0;
            cnt_q    <= 2'd0;
            ok_q     <= 1'b0;
            steps_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            ok_q     <= ok_d;
            steps_q  <= steps_d;
        end
    end

    assign rsp_ok       = ok_q;
    assign rsp_steps    = steps_q;
    assign shadow_state = shadow_q;

`ifdef ACTIV4_SYNC_CHECK_EN
    logic sync_err_q, sync_err_d;

    // The machine's y is 1 exactly in S0, so it must agree with the shadow.
    assign sync_err_d = sync_err_q | (y_in != (shadow_q == S0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`else
    logic unused_y_in;

    assign unused_y_in = y_in;
    assign sync_err    = 1'b0;
`endif

endmodule

// File: tb/tb_activ4_driver.sv
// Directed bench for activ4_driver: emulates the driven machine to supply y_in
// and compares every observation against hand-derived expected values.
module tb_activ4_driver;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_target;
    logic       rsp_valid;
    logic       rsp_ok;
    logic [1:0] rsp_steps;
    logic       x_out;
    logic       y_in;
    logic [2:0] shadow_state;
    logic       sync_err;

    int total;
    int bad;

    logic [2:0] m_q;
    logic       force_y;

`ifdef ACTIV4_SYNC_CHECK_EN
    localparam logic SYNC_EXP = 1'b1;
`else
    localparam logic SYNC_EXP = 1'b0;
`endif

    typedef struct {
        bit         rst;
        logic [2:0] tgt;
        int         lat;
        logic       ok;
        logic [1:0] steps;
        logic [31:0] xs;   // nibble i = x_out in cycle i after accept
        logic [31:0] shs;  // nibble i = shadow state in cycle i after accept
    } route_vec_t;

    activ4_driver dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_target   (req_target),
        .rsp_valid    (rsp_valid),
        .rsp_ok       (rsp_ok),
        .rsp_steps    (rsp_steps),
        .x_out        (x_out),
        .y_in         (y_in),
        .shadow_state (shadow_state),
        .sync_err     (sync_err)
    );

    // ---------------- clock / reset / machine emulation ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] machine_next(input logic [2:0] s, input logic x);
        case (s)
            3'd0: return x ? 3'd1 : 3'd5;
            3'd1: return x ? 3'd2 : 3'd3;
            3'd2: return x ? 3'd4 : 3'd5;
            3'd3: return x ? 3'd2 : 3'd3;
            3'd4: return x ? 3'd2 : 3'd3;
            3'd5: return x ? 3'd1 : 3'd5;
            3'd6: return x ? 3'd7 : 3'd6;
            default: return x ? 3'd0 : 3'd6;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_q <= 3'd0;
        else       m_q <= machine_next(m_q, x_out);
    end

    assign y_in = force_y | (m_q == 3'd0);

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Presents a request (optionally straight out of reset) and records x_out
    // and shadow_state per cycle until rsp_valid, with a bounded wait.
    task automatic issue_request(input bit with_reset, input logic [2:0] tgt,
                                 output int lat, output logic [7:0] x_tr,
                                 output logic [7:0][2:0] sh_tr,
                                 output logic ok, output logic [1:0] steps);
        lat   = -1;
        x_tr  = '0;
        sh_tr = '0;
        ok    = 1'b0;
        steps = 2'd0;
        if (with_reset) begin
            reset      = 1'b1;
            req_valid  = 1'b1;
            req_target = tgt;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid  = 1'b1;
            req_target = tgt;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            x_tr[c]  = x_out;
            sh_tr[c] = shadow_state;
            if (rsp_valid) begin
                lat   = c;
                ok    = rsp_ok;
                steps = rsp_steps;
                break;
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (x_out !== 1'b0) begin bad++; $display("FAIL reset_x: got %b want 0", x_out); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_ok !== 1'b0) begin bad++; $display("FAIL reset_rsp_ok: got %b want 0", rsp_ok); end
        total++; if (rsp_steps !== 2'd0) begin bad++; $display("FAIL reset_rsp_steps: got %0d want 0", rsp_steps); end
        total++; if (shadow_state !== 3'd0) begin bad++; $display("FAIL reset_shadow: got %0d want 0", shadow_state); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", req_ready); end
        total++; if (x_out !== 1'b0) begin bad++; $display("FAIL idle_x: got %b want 0", x_out); end
    endtask

    task automatic test_routes();
        route_vec_t       v [11];
        int               lat;
        logic [7:0]       x_tr;
        logic [7:0][2:0]  sh_tr;
        logic             ok;
        logic [1:0]       steps;
        v = '{
            '{1'b1, 3'd4, 4, 1'b1, 2'd3, 32'h0000_0111, 32'h0003_4210},  // S0 -> S4
            '{1'b1, 3'd0, 1, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_0050},  // S0 arrived
            '{1'b1, 3'd6, 1, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0050},  // S6 unreachable
            '{1'b0, 3'd1, 2, 1'b1, 2'd1, 32'h0000_0001, 32'h0000_0315},  // S5 -> S1
            '{1'b0, 3'd1, 4, 1'b1, 2'd3, 32'h0000_0101, 32'h0003_1523},  // S3 -> S1
            '{1'b0, 3'd2, 2, 1'b1, 2'd1, 32'h0000_0001, 32'h0000_0523},  // S3 -> S2
            '{1'b0, 3'd4, 4, 1'b1, 2'd3, 32'h0000_0111, 32'h0003_4215},  // S5 -> S4
            '{1'b0, 3'd5, 3, 1'b1, 2'd2, 32'h0000_0001, 32'h0000_5523},  // S3 -> S5
            '{1'b0, 3'd7, 1, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0055},  // S7 unreachable
            '{1'b0, 3'd5, 1, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_0055},  // S5 arrived
            '{1'b0, 3'd3, 3, 1'b1, 2'd2, 32'h0000_0001, 32'h0000_3315}   // S5 -> S3
        };
        for (int n = 0; n < 11; n++) begin
            issue_request(v[n].rst, v[n].tgt, lat, x_tr, sh_tr, ok, steps);
            total++; if (lat !== v[n].lat) begin bad++; $display("FAIL route%0d_latency: got %0d want %0d", n, lat, v[n].lat); end
            total++; if (ok !== v[n].ok) begin bad++; $display("FAIL route%0d_ok: got %b want %b", n, ok, v[n].ok); end
            total++; if (steps !== v[n].steps) begin bad++; $display("FAIL route%0d_steps: got %0d want %0d", n, steps, v[n].steps); end
            for (int i = 0; i <= v[n].lat; i++) begin
                total++;
                if (x_tr[i] !== v[n].xs[i*4]) begin
                    bad++; $display("FAIL route%0d_x_cycle%0d: got %b want %b", n, i, x_tr[i], v[n].xs[i*4]);
                end
                total++;
                if (sh_tr[i] !== v[n].shs[i*4 +: 3]) begin
                    bad++; $display("FAIL route%0d_shadow_cycle%0d: got %0d want %0d", n, i, sh_tr[i], v[n].shs[i*4 +: 3]);
                end
            end
        end
    endtask

    // Follows test_routes directly: its last response was ok=1, steps=2.
    task automatic test_hold_response();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_valid_c%0d: got %b want 0", c, rsp_valid); end
            total++; if (rsp_ok !== 1'b1) begin bad++; $display("FAIL hold_ok_c%0d: got %b want 1", c, rsp_ok); end
            total++; if (rsp_steps !== 2'd2) begin bad++; $display("FAIL hold_steps_c%0d: got %0d want 2", c, rsp_steps); end
        end
    endtask

    task automatic test_ignore_during_drive();
        logic [8:0] exp_ready;
        logic [8:0] exp_x;
        logic [8:0] exp_rv;
        exp_ready = 9'b000100001;
        exp_x     = 9'b000100111;
        exp_rv    = 9'b100010000;
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_target = 3'd4;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            total++; if (req_ready !== exp_ready[c]) begin bad++; $display("FAIL ignore_ready_c%0d: got %b want %b", c, req_ready, exp_ready[c]); end
            total++; if (x_out !== exp_x[c]) begin bad++; $display("FAIL ignore_x_c%0d: got %b want %b", c, x_out, exp_x[c]); end
            total++; if (rsp_valid !== exp_rv[c]) begin bad++; $display("FAIL ignore_rsp_valid_c%0d: got %b want %b", c, rsp_valid, exp_rv[c]); end
            if (c == 4) begin
                total++; if (rsp_steps !== 2'd3) begin bad++; $display("FAIL ignore_first_steps: got %0d want 3", rsp_steps); end
            end
            if (c == 8) begin
                total++; if (rsp_steps !== 2'd2) begin bad++; $display("FAIL ignore_second_steps: got %0d want 2", rsp_steps); end
                total++; if (rsp_ok !== 1'b1) begin bad++; $display("FAIL ignore_second_ok: got %b want 1", rsp_ok); end
            end
            @(posedge clk);
            #1;
            if (c == 0) req_target = 3'd5;
            if (c == 5) req_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_drive();
        int n_rv;
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_target = 3'd4;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL middrive_busy: got %b want 0", req_ready); end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        total++; if (shadow_state !== 3'd0) begin bad++; $display("FAIL middrive_shadow: got %0d want 0", shadow_state); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL middrive_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL middrive_ready: got %b want 1", req_ready); end
        total++; if (x_out !== 1'b0) begin bad++; $display("FAIL middrive_x: got %b want 0", x_out); end
        total++; if (rsp_ok !== 1'b0) begin bad++; $display("FAIL middrive_ok: got %b want 0", rsp_ok); end
        total++; if (rsp_steps !== 2'd0) begin bad++; $display("FAIL middrive_steps: got %0d want 0", rsp_steps); end
        @(posedge clk);
        #1 reset = 1'b0;
        n_rv = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) n_rv++;
        end
        total++; if (n_rv !== 0) begin bad++; $display("FAIL middrive_no_response: got %0d pulses want 0", n_rv); end
    endtask

    // Follows test_reset_mid_drive: idle with x=0 parks the machine in S5.
    task automatic test_sync();
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sync_clean_run: got %b want 0", sync_err); end
        total++; if (shadow_state !== 3'd5) begin bad++; $display("FAIL sync_parked: got %0d want 5", shadow_state); end
        @(posedge clk);
        #1 force_y = 1'b1;
        @(negedge clk);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sync_before_edge: got %b want 0", sync_err); end
        @(posedge clk);
        #1 force_y = 1'b0;
        @(negedge clk);
        total++; if (sync_err !== SYNC_EXP) begin bad++; $display("FAIL sync_set: got %b want %b", sync_err, SYNC_EXP); end
        repeat (3) @(negedge clk);
        total++; if (sync_err !== SYNC_EXP) begin bad++; $display("FAIL sync_sticky: got %b want %b", sync_err, SYNC_EXP); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sync_reset: got %b want 0", sync_err); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sync_after_reset: got %b want 0", sync_err); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_target = 3'd0;
        force_y    = 1'b0;
        test_reset();
        test_routes();
        test_hold_response();
        test_ignore_during_drive();
        test_reset_mid_drive();
        test_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
